// File: rtl/fetch_queue.sv
// fetch_queue: circular fetch-to-decode instruction buffer that tags entries issued
// behind unresolved branches/JALRs and stalls decode when the shadow depth is exhausted.
module fetch_queue #(
  parameter int DEPTH = 8,
  parameter int MAX_SHADOW = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              flush,
  input  logic                              enq_valid,
  output logic                              enq_ready,
  input  logic [31:0]                       enq_instr,
  input  logic [31:0]                       enq_pc,
  output logic                              deq_valid,
  input  logic                              deq_ready,
  output logic [31:0]                       deq_instr,
  output logic [31:0]                       deq_pc,
  output logic                              deq_under_shadow,
  input  logic                              br_resolve,
  output logic [$clog2(DEPTH):0]            count,
  output logic [$clog2(MAX_SHADOW+1)-1:0]   shadow_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int SW = $clog2(MAX_SHADOW + 1);
  logic [63:0]   mem_q [DEPTH];
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [SW-1:0] shadow_cnt_q, shadow_cnt_d;
  logic [63:0]   head_entry;
  logic          empty, full, is_shadow_op, enq_fire, deq_fire, inc, dec;
  always_comb begin
    head_entry       = mem_q[head_q[AW-1:0]];
    empty            = head_q == tail_q;
    full             = (head_q[AW-1:0] == tail_q[AW-1:0]) && (head_q[AW] != tail_q[AW]);
    is_shadow_op     = (head_entry[38:32] == 7'b1100011) || (head_entry[38:32] == 7'b1100111);
    enq_ready        = !full && !flush;
    deq_valid        = !empty && !flush &&
                       !(is_shadow_op && shadow_cnt_q == SW'(MAX_SHADOW) && !br_resolve);
    enq_fire         = enq_valid && enq_ready;
    deq_fire         = deq_valid && deq_ready;
    inc              = deq_fire && is_shadow_op;
    dec              = br_resolve && shadow_cnt_q != '0;
    head_d           = flush ? '0 : head_q + PW'(deq_fire);
    tail_d           = flush ? '0 : tail_q + PW'(enq_fire);
    shadow_cnt_d     = flush ? '0 : shadow_cnt_q + SW'(inc) - SW'(dec);
    deq_instr        = empty ? '0 : head_entry[63:32];
    deq_pc           = empty ? '0 : head_entry[31:0];
    deq_under_shadow = !empty && shadow_cnt_q != '0;
    count            = tail_q - head_q;
    shadow_cnt       = shadow_cnt_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      head_q       <= '0;
      tail_q       <= '0;
      shadow_cnt_q <= '0;
    end else begin
      head_q       <= head_d;
      tail_q       <= tail_d;
      shadow_cnt_q <= shadow_cnt_d;
    end
  // Storage needs no reset: pointers alone define which entries are live.
  always_ff @(posedge clk)
    if (enq_fire) mem_q[tail_q[AW-1:0]] <= {enq_instr, enq_pc};
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed and randomized checks of fetch_queue against a queue-based model.
module tb_fetch_queue;
  localparam int DEPTH = 8;
  localparam int MAX_SHADOW = 4;
  localparam logic [31:0] ADDI = 32'h00100093;
  localparam logic [31:0] BEQ  = 32'h00000063;
  logic clk = 1'b0;
  logic rst_n, flush, enq_valid, enq_ready, deq_valid, deq_ready, deq_under_shadow, br_resolve;
  logic [31:0] enq_instr, enq_pc, deq_instr, deq_pc;
  logic [3:0] count;
  logic [2:0] shadow_cnt;
  int total = 0;
  int bad = 0;
  logic [63:0] mq[$];
  int msh = 0;

  fetch_queue #(.DEPTH(DEPTH), .MAX_SHADOW(MAX_SHADOW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .enq_valid(enq_valid), .enq_ready(enq_ready),
    .enq_instr(enq_instr), .enq_pc(enq_pc), .deq_valid(deq_valid), .deq_ready(deq_ready),
    .deq_instr(deq_instr), .deq_pc(deq_pc), .deq_under_shadow(deq_under_shadow),
    .br_resolve(br_resolve), .count(count), .shadow_cnt(shadow_cnt)
  );

  always #5 clk = ~clk;

  function automatic bit is_sh(logic [31:0] i);
    return i[6:0] == 7'b1100011 || i[6:0] == 7'b1100111;
  endfunction

  function automatic bit m_deq_valid();
    if (mq.size() == 0 || flush) return 1'b0;
    return !(is_sh(mq[0][63:32]) && msh == MAX_SHADOW && !br_resolve);
  endfunction

  task automatic idle();
    flush = 0; enq_valid = 0; deq_ready = 0; br_resolve = 0; enq_instr = '0; enq_pc = '0;
  endtask

  // Advance one clock and apply the same cycle's events to the model.
  task automatic tick();
    bit ef, df;
    int old;
    @(posedge clk);
    ef = enq_valid && mq.size() < DEPTH && !flush;
    df = deq_ready && m_deq_valid();
    old = msh;
    if (flush) begin
      mq.delete();
      msh = 0;
    end else begin
      if (df) begin
        if (is_sh(mq[0][63:32])) msh++;
        void'(mq.pop_front());
      end
      if (br_resolve && old != 0) msh--;
      if (ef) mq.push_back({enq_instr, enq_pc});
    end
    #1;
  endtask

  task automatic push(logic [31:0] i, logic [31:0] p);
    enq_valid = 1; enq_instr = i; enq_pc = p;
    tick();
    idle();
  endtask

  task automatic test_reset();
    #2;
    total++; if (count !== 4'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", count); end
    total++; if (enq_ready !== 1'b1) begin bad++; $display("FAIL reset_enq_ready got=%b want=1", enq_ready); end
    total++; if (deq_valid !== 1'b0) begin bad++; $display("FAIL reset_deq_valid got=%b want=0", deq_valid); end
    total++; if (shadow_cnt !== 3'd0) begin bad++; $display("FAIL reset_shadow got=%0d want=0", shadow_cnt); end
    total++; if ({deq_instr, deq_pc, deq_under_shadow} !== 65'd0) begin bad++; $display("FAIL reset_deq_data got=%h/%h/%b want=0", deq_instr, deq_pc, deq_under_shadow); end
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    for (int i = 0; i < 3; i++) push(ADDI, 32'h60 + 4 * i);
    @(negedge clk);
    total++; if (count !== 4'd3) begin bad++; $display("FAIL basic_count got=%0d want=3", count); end
    total++; if (deq_pc !== 32'h60) begin bad++; $display("FAIL basic_head_pc got=%h want=60", deq_pc); end
    total++; if (deq_under_shadow !== 1'b0) begin bad++; $display("FAIL basic_shadow got=%b want=0", deq_under_shadow); end
    tick();
    for (int i = 0; i < 3; i++) begin
      deq_ready = 1;
      @(negedge clk);
      total++; if (deq_valid !== 1'b1 || deq_pc !== 32'h60 + 4 * i || deq_instr !== ADDI) begin bad++; $display("FAIL basic_deq%0d got=%b/%h/%h want=1/%h/%h", i, deq_valid, deq_pc, deq_instr, 32'h60 + 4 * i, ADDI); end
      tick();
    end
    idle();
    total++; if (count !== 4'd0) begin bad++; $display("FAIL basic_drained got=%0d want=0", count); end
  endtask

  task automatic test_full_wrap();
    for (int i = 0; i < DEPTH; i++) push(ADDI, 32'h200 + 4 * i);
    enq_valid = 1; deq_ready = 1; enq_instr = ADDI; enq_pc = 32'hBAD0;
    @(negedge clk);
    total++; if (enq_ready !== 1'b0) begin bad++; $display("FAIL full_enq_ready got=%b want=0", enq_ready); end
    total++; if (count !== 4'd8) begin bad++; $display("FAIL full_count got=%0d want=8", count); end
    tick();
    total++; if (count !== 4'd7) begin bad++; $display("FAIL full_after got=%0d want=7", count); end
    for (int i = 0; i < 20; i++) begin
      enq_valid = 1; deq_ready = 1; enq_instr = ADDI; enq_pc = 32'h400 + 4 * i;
      @(negedge clk);
      total++; if (deq_pc !== mq[0][31:0] || deq_valid !== 1'b1) begin bad++; $display("FAIL wrap_pair%0d got=%b/%h want=1/%h", i, deq_valid, deq_pc, mq[0][31:0]); end
      tick();
    end
    idle();
    while (mq.size() > 0) begin
      deq_ready = 1;
      @(negedge clk);
      total++; if (deq_pc !== mq[0][31:0] || deq_pc == 32'hBAD0) begin bad++; $display("FAIL wrap_drain got=%h want=%h", deq_pc, mq[0][31:0]); end
      tick();
    end
    idle();
  endtask

  task automatic test_shadow();
    push(BEQ, 32'h100); push(ADDI, 32'h104); push(ADDI, 32'h108);
    deq_ready = 1;
    @(negedge clk);
    total++; if (deq_pc !== 32'h100 || deq_under_shadow !== 1'b0) begin bad++; $display("FAIL shadow_beq got=%h/%b want=100/0", deq_pc, deq_under_shadow); end
    tick();
    @(negedge clk);
    total++; if (deq_pc !== 32'h104 || deq_under_shadow !== 1'b1 || shadow_cnt !== 3'd1) begin bad++; $display("FAIL shadow_tag got=%h/%b/%0d want=104/1/1", deq_pc, deq_under_shadow, shadow_cnt); end
    tick();
    idle(); br_resolve = 1;
    tick();
    idle();
    @(negedge clk);
    total++; if (shadow_cnt !== 3'd0 || deq_pc !== 32'h108 || deq_under_shadow !== 1'b0) begin bad++; $display("FAIL shadow_resolved got=%0d/%h/%b want=0/108/0", shadow_cnt, deq_pc, deq_under_shadow); end
    deq_ready = 1; tick(); idle();
  endtask

  task automatic test_stall();
    for (int i = 0; i < 5; i++) push(BEQ, 32'h500 + 4 * i);
    deq_ready = 1;
    for (int i = 0; i < 4; i++) tick();
    @(negedge clk);
    total++; if (shadow_cnt !== 3'd4) begin bad++; $display("FAIL stall_cnt got=%0d want=4", shadow_cnt); end
    total++; if (deq_valid !== 1'b0 || deq_pc !== 32'h510) begin bad++; $display("FAIL stall_valid got=%b/%h want=0/510", deq_valid, deq_pc); end
    tick();
    br_resolve = 1;
    @(negedge clk);
    total++; if (deq_valid !== 1'b1) begin bad++; $display("FAIL stall_release got=%b want=1", deq_valid); end
    tick();
    idle();
    total++; if (shadow_cnt !== 3'd4 || count !== 4'd0) begin bad++; $display("FAIL stall_after got=%0d/%0d want=4/0", shadow_cnt, count); end
    br_resolve = 1;
    for (int i = 0; i < 6; i++) tick();
    idle();
    total++; if (shadow_cnt !== 3'd0) begin bad++; $display("FAIL stall_drain got=%0d want=0", shadow_cnt); end
  endtask

  task automatic test_flush();
    push(BEQ, 32'h600); push(BEQ, 32'h604);
    for (int i = 0; i < 5; i++) push(ADDI, 32'h608 + 4 * i);
    deq_ready = 1; tick(); tick(); idle();
    total++; if (shadow_cnt !== 3'd2 || count !== 4'd5) begin bad++; $display("FAIL flush_setup got=%0d/%0d want=2/5", shadow_cnt, count); end
    flush = 1; enq_valid = 1; deq_ready = 1; br_resolve = 1; enq_instr = ADDI; enq_pc = 32'h700;
    @(negedge clk);
    total++; if (enq_ready !== 1'b0 || deq_valid !== 1'b0) begin bad++; $display("FAIL flush_hs got=%b/%b want=0/0", enq_ready, deq_valid); end
    tick();
    idle();
    total++; if (count !== 4'd0 || shadow_cnt !== 3'd0 || deq_valid !== 1'b0) begin bad++; $display("FAIL flush_after got=%0d/%0d/%b want=0/0/0", count, shadow_cnt, deq_valid); end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 6; i++) push(ADDI, 32'h800 + 4 * i);
    @(negedge clk); #2;
    rst_n = 0;
    #1;
    total++; if (count !== 4'd0 || deq_valid !== 1'b0 || shadow_cnt !== 3'd0) begin bad++; $display("FAIL async_reset got=%0d/%b/%0d want=0/0/0", count, deq_valid, shadow_cnt); end
    mq.delete(); msh = 0;
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] rand_instr();
    case ($urandom_range(0, 4))
      0: return ADDI;
      1: return {$urandom_range(0, 32'hFFFF), 9'd0, 7'b1100011};
      2: return 32'h000080E7;
      3: return 32'h0080006F;
      default: return $urandom;
    endcase
  endfunction

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      enq_valid = $urandom_range(0, 3) != 0; enq_instr = rand_instr(); enq_pc = $urandom;
      deq_ready = $urandom_range(0, 2) != 0; br_resolve = $urandom_range(0, 3) == 0;
      flush = $urandom_range(0, 39) == 0;
      @(negedge clk);
      total++; if (count !== 4'(mq.size())) begin bad++; $display("FAIL rnd_count n=%0d got=%0d want=%0d", n, count, mq.size()); end
      total++; if (shadow_cnt !== 3'(msh)) begin bad++; $display("FAIL rnd_shadow n=%0d got=%0d want=%0d", n, shadow_cnt, msh); end
      total++; if (enq_ready !== (mq.size() < DEPTH && !flush)) begin bad++; $display("FAIL rnd_enq_ready n=%0d got=%b", n, enq_ready); end
      total++; if (deq_valid !== m_deq_valid()) begin bad++; $display("FAIL rnd_deq_valid n=%0d got=%b want=%b", n, deq_valid, m_deq_valid()); end
      total++; if ({deq_instr, deq_pc} !== (mq.size() ? mq[0] : 64'd0)) begin bad++; $display("FAIL rnd_head n=%0d got=%h%h", n, deq_instr, deq_pc); end
      total++; if (deq_under_shadow !== (mq.size() > 0 && msh != 0)) begin bad++; $display("FAIL rnd_tag n=%0d got=%b", n, deq_under_shadow); end
      tick();
    end
    idle();
  endtask

  initial begin
    rst_n = 0;
    idle();
    test_reset();
    test_basic();
    test_full_wrap();
    test_shadow();
    test_stall();
    test_flush();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
